hulohot_alu_arbiter: RTL and testbench
======================================

# hulohot_alu_arbiter

Round-robin arbiter and sequencer that shares one 3-bit ALU (add/sub/and/or, 4-bit result) among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode ports from registers. It samples the ALU's combinational result one cycle later and returns it with the requester ID over a valid/ready response channel. It sits between the requesting control logic and the ALU instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal 2..8.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ: per-requester request valid.
- `req_ready`  out  NUM_REQ: per-requester accept strobe; at most one bit high.
- `req_a`  in  3*NUM_REQ: operand a, requester i at [3i+2:3i].
- `req_b`  in  3*NUM_REQ: operand b, same packing.
- `req_opcode`  in  2*NUM_REQ: opcode, requester i at [2i+1:2i]; 00 ADD, 01 SUB, 10 AND, 11 OR.
- `alu_a`, `alu_b`  out  3 each: registered operands to the ALU.
- `alu_opcode`  out  2: registered opcode to the ALU.
- `alu_z`  in  4: combinational ALU result.
- `rsp_valid`  out  1: response valid.
- `rsp_ready`  in  1: response consumer ready.
- `rsp_data`  out  4: captured ALU result.
- `rsp_id`  out  3: index of the requester served.
- `busy`  out  1: high in any state other than IDLE.
- `done_count`  out  16: completed responses; present only with `ALU_ARB_STATS_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` bit is set, grant g is the first set bit searching upward from `ptr` and wrapping modulo NUM_REQ.
  - `req_ready[g]` goes high combinationally for that cycle.
  - On the clock edge: latch `req_a`/`req_b`/`req_opcode` of g into `alu_a`/`alu_b`/`alu_opcode`, set `rsp_id`=g, set `ptr`=(g+1) mod NUM_REQ, and go to EXEC.
  - If no `req_valid` bit is set, stay in IDLE.
- **EXEC**
  - `alu_*` are stable.
  - On the clock edge: `rsp_data` <= `alu_z`, go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data` and `rsp_id` are held stable.
  - On an edge with `rsp_ready`=1, return to IDLE.
  - Otherwise hold indefinitely; no new grant is issued.
- `req_ready` is 0 in EXEC and RESP. Requesters hold `req_valid` and their operands stable until they see `req_ready`.
- A requester that drops `req_valid` before being granted is simply skipped.
- `alu_*` keep their last value after the transaction completes.
- Results are 4-bit, exactly as produced by the ALU:
  - SUB wraps two's-complement, e.g. 3-5 = 4'hE.
  - ADD carries into bit 3, e.g. 7+7 = 4'hE.
  - AND/OR zero-extend the 3-bit result.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced.
- Reset values: state IDLE, `ptr`=0, `req_ready`=0, `alu_a`=`alu_b`=0, `alu_opcode`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `done_count`=0.

## Timing
- Cycle T (IDLE, request present): `req_ready[g]` is high during T.
- Cycle T+1 (EXEC): `alu_*` reflect the granted operands.
- Cycle T+2 (RESP): `rsp_valid` is high with the result; request-to-response latency is 2 cycles.
- If `rsp_ready`=1 in T+2, the block is in IDLE at T+3 and the next grant can occur then. Maximum throughput is 1 operation per 3 cycles.
- `rsp_valid` falls in the cycle after the accepting edge.
- `busy` is registered and is high in EXEC and RESP.
- The ALU is combinational; its path from `alu_*` to `alu_z` must close within one cycle.
- Reset asserts asynchronously; all outputs reach their reset values immediately. Deassertion is synchronous to `clk` (externally synchronized).

## Configuration
- **`ALU_ARB_STATS_EN` defined:** the `done_count` port exists.
  - It increments on every RESP edge with `rsp_ready`=1.
  - It saturates at 16'hFFFF and resets to 0.
- **`ALU_ARB_STATS_EN` undefined:** the port and counter are absent; all other behaviour is identical.

## Test plan
- **Single SUB:** NUM_REQ=4; requester 1 presents a=3, b=5, op=01; `rsp_ready`=1.
  - `req_ready`=4'b0010 in cycle T.
  - `rsp_valid`=1 at T+2 with `rsp_data`=4'hE and `rsp_id`=1.
  - IDLE at T+3.
- **Round-robin fairness:** all four requesters held valid from reset; `rsp_ready`=1.
  - Grant order is 0,1,2,3,0, one grant every 3 cycles.
- **Backpressure:** `rsp_ready`=0 for 5 cycles during RESP, with requesters 0 and 2 valid.
  - `rsp_valid`, `rsp_data` and `rsp_id` stay stable and `req_ready` stays 0.
  - After `rsp_ready`=1 the next grant goes to the requester after the one just served.
- **Opcode coverage:** expected `rsp_data` values:
  - a=7, b=7, ADD gives 4'hE.
  - a=6, b=3, AND gives 4'h2.
  - a=4, b=1, OR gives 4'h5.
  - a=5, b=2, SUB gives 4'h3.
- **Reset during RESP:** pull `rst_n` low while `rsp_valid`=1.
  - All outputs go to 0 in the same cycle with no clock edge.
  - After release, the first grant with all requesters valid goes to requester 0.
- **Stats (`ALU_ARB_STATS_EN`):** complete 3 transactions.
  - `done_count`=3.
  - A transaction stalled in RESP does not increment it until accepted.

Source files
------------

// File: rtl/hulohot_alu_arbiter.sv
// rtl/hulohot_alu_arbiter.sv - round-robin arbiter/sequencer sharing one ALU among NUM_REQ requesters
// Optional feature: define ALU_ARB_STATS_EN to add the saturating done_count port.
module hulohot_alu_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_a,
    input  logic [3*NUM_REQ-1:0]   req_b,
    input  logic [2*NUM_REQ-1:0]   req_opcode,
    output logic [2:0]             alu_a,
    output logic [2:0]             alu_b,
    output logic [1:0]             alu_opcode,
    input  logic [3:0]             alu_z,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [3:0]             rsp_data,
    output logic [2:0]             rsp_id,
    output logic                   busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]            done_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0] state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] alu_a_q, alu_a_d;
    logic [2:0] alu_b_q, alu_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [3:0] rsp_data_q, rsp_data_d;
    logic [2:0] rsp_id_q, rsp_id_d;
    logic       busy_q, busy_d;

    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [NUM_REQ-1:0]   valid_rot;
    logic                 gnt_found;
    logic [2:0]           gnt_off;
    logic [3:0]           gnt_sum;
    logic [2:0]           gnt_idx;
    logic                 grant;

    // Rotate the valid vector so bit 0 is the requester at ptr; the lowest set bit wins.
    always_comb begin
        valid_dbl = {req_valid, req_valid};
        valid_rot = valid_dbl[ptr_q +: NUM_REQ];
        gnt_found = 1'b0;
        gnt_off   = 3'd0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                gnt_found = 1'b1;
                gnt_off   = 3'(k);
            end
        end
        gnt_sum = 4'(ptr_q) + 4'(gnt_off);
        if (gnt_sum >= 4'(NUM_REQ)) begin
            gnt_sum = gnt_sum - 4'(NUM_REQ);
        end
        gnt_idx = gnt_sum[2:0];
    end

    assign grant     = (state_q == ST_IDLE) && gnt_found;
    assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_op_d   = alu_op_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    alu_a_d  = req_a[3*gnt_idx +: 3];
                    alu_b_d  = req_b[3*gnt_idx +: 3];
                    alu_op_d = req_opcode[2*gnt_idx +: 2];
                    rsp_id_d = gnt_idx;
                    ptr_d    = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_z;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            alu_a_q    <= 3'd0;
            alu_b_q    <= 3'd0;
            alu_op_q   <= 2'd0;
            rsp_data_q <= 4'd0;
            rsp_id_q   <= 3'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            busy_q     <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign busy       = busy_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] done_cnt_q, done_cnt_d;

    always_comb begin
        done_cnt_d = done_cnt_q;
        if ((state_q == ST_RESP) && rsp_ready && (done_cnt_q != 16'hFFFF)) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= 16'd0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_count = done_cnt_q;
`endif

endmodule

// File: tb/tb_hulohot_alu_arbiter.sv
// tb/tb_hulohot_alu_arbiter.sv - directed-vector bench for hulohot_alu_arbiter
module tb_hulohot_alu_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_a;
    logic [3*N-1:0] req_b;
    logic [2*N-1:0] req_opcode;
    logic [2:0]     alu_a;
    logic [2:0]     alu_b;
    logic [1:0]     alu_opcode;
    logic [3:0]     alu_z;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [3:0]     rsp_data;
    logic [2:0]     rsp_id;
    logic           busy;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]    done_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hulohot_alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_opcode (req_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_z      (alu_z),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .busy       (busy)
`ifdef ALU_ARB_STATS_EN
        ,
        .done_count (done_count)
`endif
    );

    // Reference combinational ALU attached to the arbiter
    always_comb begin
        case (alu_opcode)
            2'b00:   alu_z = {1'b0, alu_a} + {1'b0, alu_b};
            2'b01:   alu_z = {1'b0, alu_a} - {1'b0, alu_b};
            2'b10:   alu_z = {1'b0, alu_a & alu_b};
            default: alu_z = {1'b0, alu_a | alu_b};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [2:0] a, input logic [2:0] b, input logic [1:0] op);
        req_a[3*id +: 3]      = a;
        req_b[3*id +: 3]      = b;
        req_opcode[2*id +: 2] = op;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Single requester transaction; entered and left at a negedge in IDLE.
    task automatic do_op(input string tag, input int id, input logic [2:0] a, input logic [2:0] b,
                         input logic [1:0] op, input logic [3:0] exp);
        set_req(id, a, b, op);
        req_valid = 4'b0001 << id;
        rsp_ready = 1'b1;
        #1;
        check({tag, "_ready"}, req_ready, 4'b0001 << id);
        @(negedge clk);
        req_valid = '0;
        check({tag, "_alu_a"}, alu_a, a);
        check({tag, "_alu_b"}, alu_b, b);
        check({tag, "_alu_op"}, alu_opcode, op);
        check({tag, "_busy_exec"}, busy, 1);
        @(negedge clk);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_data"}, rsp_data, exp);
        check({tag, "_rsp_id"}, rsp_id, id);
        @(negedge clk);
        check({tag, "_idle_valid"}, rsp_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        rsp_ready  = 1'b0;
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_op", alu_opcode, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
`ifdef ALU_ARB_STATS_EN
        check("rst_done_count", done_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single SUB from requester 1
        @(negedge clk);
        do_op("sub31", 1, 3'd3, 3'd5, 2'b01, 4'hE);

        // Opcode coverage
        do_op("add77", 0, 3'd7, 3'd7, 2'b00, 4'hE);
        do_op("and63", 2, 3'd6, 3'd3, 2'b10, 4'h2);
        do_op("or41",  3, 3'd4, 3'd1, 2'b11, 4'h5);
        do_op("sub52", 1, 3'd5, 3'd2, 2'b01, 4'h3);

        // Round-robin fairness with all requesters held valid from reset
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 3'(i), 3'd1, 2'b00);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            automatic int exp_id = g % N;
            check($sformatf("rr%0d_ready", g), req_ready, 4'b0001 << exp_id);
            @(negedge clk);
            check($sformatf("rr%0d_exec_ready", g), req_ready, 0);
            @(negedge clk);
            check($sformatf("rr%0d_rsp_id", g), rsp_id, exp_id);
            check($sformatf("rr%0d_rsp_data", g), rsp_data, exp_id + 1);
            @(negedge clk);
        end
        req_valid = '0;

        // Backpressure with requesters 0 and 2 valid
        do_reset();
        set_req(0, 3'd2, 3'd3, 2'b00);
        set_req(2, 3'd6, 3'd5, 2'b11);
        req_valid = 4'b0101;
        rsp_ready = 1'b0;
        #1;
        check("bp_grant0", req_ready, 4'b0001);
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), rsp_valid, 1);
            check($sformatf("bp%0d_data", c), rsp_data, 4'h5);
            check($sformatf("bp%0d_id", c), rsp_id, 0);
            check($sformatf("bp%0d_ready", c), req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 0);
        check("bp_next_grant", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("bp_next_data", rsp_data, 4'h7);
        check("bp_next_id", rsp_id, 2);
        @(negedge clk);

        // Reset asserted while a response is pending
        set_req(3, 3'd5, 3'd6, 2'b11);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("rr_pre_valid", rsp_valid, 1);
        check("rr_pre_data", rsp_data, 4'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_valid", rsp_valid, 0);
        check("rr_data", rsp_data, 0);
        check("rr_id", rsp_id, 0);
        check("rr_busy", busy, 0);
        check("rr_alu_a", alu_a, 0);
        check("rr_alu_b", alu_b, 0);
        check("rr_alu_op", alu_opcode, 0);
        req_valid = 4'b1111;
        check("rr_ready_in_reset", req_ready, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("rr_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);

`ifdef ALU_ARB_STATS_EN
        do_reset();
        do_op("st1", 0, 3'd1, 3'd1, 2'b00, 4'h2);
        do_op("st2", 1, 3'd2, 3'd1, 2'b00, 4'h3);
        do_op("st3", 2, 3'd3, 3'd1, 2'b00, 4'h4);
        check("stats_three", done_count, 3);
        set_req(3, 3'd1, 3'd0, 2'b11);
        req_valid = 4'b1000;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("stats_stalled", done_count, 3);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("stats_accepted", done_count, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
